instmem_loader: RTL

- Writer side of the instruction memory: boot loader that receives a byte stream and fills a writable instruction memory with 32-bit instruction words.
- Sits between a byte source (UART receiver / debug port) and the instruction memory write port.
- Holds the core in reset via cpu_hold while loading.
- Stream format: 16-bit word count N (big-endian), then 4*N instruction bytes (big-endian per word).

---
 rtl/instmem_loader_if.sv | 18 +
 rtl/instmem_loader.sv | 121 ++++++++++++
 2 files changed

// File: rtl/instmem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// slave = loader side, master = byte source / memory side.
interface instmem_loader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int WORD_WIDTH = 32
);
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WORD_WIDTH-1:0] wr_data;

    modport slave  (input  byte_in, byte_valid,
                    output byte_ready, wr_en, wr_addr, wr_data);
    modport master (output byte_in, byte_valid,
                    input  byte_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/instmem_loader.sv
// Boot loader: takes a 16-bit big-endian word count followed by big-endian
// 32-bit words from a byte stream and writes them into instruction memory.
module instmem_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    instmem_loader_if.slave   bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_t;

    state_t                state, state_n;
    logic [15:0]           len;
    logic [1:0]            b;
    logic [ADDR_WIDTH-1:0] k;
    logic [WORD_WIDTH-1:0] word_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [WORD_WIDTH-1:0] wr_data_q;
    logic                  ready;
    logic                  accept;
    logic                  last;
    logic [15:0]           len_full;

    assign accept   = bus.byte_valid && ready;
    assign len_full = {len[15:8], bus.byte_in};
    assign last     = (32'(k) + 32'd1) == 32'(len);

    assign bus.byte_ready = ready;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            len       <= '0;
            b         <= '0;
            k         <= '0;
            word_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE, S_DONE, S_ERR: if (start) begin
                    b <= '0;
                    k <= '0;
                end
                S_LEN_HI: if (accept) len[15:8] <= bus.byte_in;
                S_LEN_LO: if (accept) len[7:0]  <= bus.byte_in;
                S_DATA: if (accept) begin
                    // Shifting in MSB-first puts byte 0 in bits [31:24].
                    word_q <= {word_q[WORD_WIDTH-9:0], bus.byte_in};
                    b      <= b + 2'd1;
                    if (b == 2'd3) begin
                        wr_data_q <= {word_q[WORD_WIDTH-9:0], bus.byte_in};
                        wr_addr_q <= k;
                    end
                end
                S_WRITE: if (!last) begin
                    k <= k + 1'b1;
                    b <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n    = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        cpu_hold   = 1'b1;
        bus.wr_en  = 1'b0;
        case (state)
            S_IDLE: if (start) state_n = S_LEN_HI;
            S_LEN_HI: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (accept) state_n = S_LEN_LO;
            end
            S_LEN_LO: begin
                ready = 1'b1;
                busy  = 1'b1;
                // An empty or oversized image is rejected before any write.
                if (accept)
                    state_n = (len_full == 16'd0 || len_full > 16'(DEPTH)) ? S_ERR : S_DATA;
            end
            S_DATA: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (accept && b == 2'd3) state_n = S_WRITE;
            end
            S_WRITE: begin
                busy      = 1'b1;
                bus.wr_en = 1'b1;
                state_n   = last ? S_DONE : S_DATA;
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) state_n = S_LEN_HI;
            end
            S_ERR: begin
                error = 1'b1;
                if (start) state_n = S_LEN_HI;
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule
